// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush, downstream stall
// and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_use_rs1,
   input  logic              id_imm,
   input  logic              id_load,
   input  logic              id_store,
   input  logic [REG_AW-1:0] id_store_reg,
   input  logic [3:0]        id_alu_op,
   input  logic [XLEN-1:0]   id_op1,
   input  logic [XLEN-1:0]   id_op2,
   input  logic [XLEN-1:0]   id_store_value,
   input  logic              ex_ready,
   input  logic              flush,
   output logic              id_ready,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_imm,
   output logic              ex_load,
   output logic              ex_store,
   output logic [REG_AW-1:0] ex_store_reg,
   output logic [3:0]        ex_alu_op,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [XLEN-1:0]   ex_store_value,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic hazard;
   logic load_in_ex;
   logic rs1_hit;
   logic rs2_hit;
   logic st_hit;

   // x0 never produces a hazard because a load with rd=0 is excluded here
   assign load_in_ex = ex_valid && ex_load && (ex_rd != '0) && id_valid;
   assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit    = !id_imm && (id_rs2 == ex_rd);
   assign st_hit     = id_store && (id_store_reg == ex_rd);
   assign hazard     = load_in_ex && (rs1_hit || rs2_hit || st_hit);
   assign id_ready   = ex_ready && !hazard;

   always_ff @(posedge clk) begin
      if (rst || flush || (ex_ready && hazard)) begin
         ex_valid       <= 1'b0;
         ex_pc          <= '0;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         ex_imm         <= 1'b0;
         ex_load        <= 1'b0;
         ex_store       <= 1'b0;
         ex_store_reg   <= '0;
         ex_alu_op      <= '0;
         ex_op1         <= '0;
         ex_op2         <= '0;
         ex_store_value <= '0;
      end else if (ex_ready) begin
         ex_valid       <= id_valid;
         ex_pc          <= id_pc;
         ex_rs1         <= id_rs1;
         ex_rs2         <= id_rs2;
         ex_rd          <= id_valid ? id_rd : '0;
         ex_imm         <= id_imm;
         ex_load        <= id_valid && id_load;
         ex_store       <= id_valid && id_store;
         ex_store_reg   <= id_store_reg;
         ex_alu_op      <= id_alu_op;
         ex_op1         <= id_op1;
         ex_op2         <= id_op2;
         ex_store_value <= id_store_value;
      end
   end

   // Only a genuine load-use bubble counts; flush and reset bubbles do not
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (!flush && ex_ready && hazard && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule
